// File: rtl/byte_serializer_pkg.sv
// byte_serializer_pkg: shared state type and default width for the byte serializer
package byte_serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEFAULT_DATA_W = 8;
endpackage

// File: rtl/word_hold_reg.sv
// word_hold_reg: one-entry word buffer with full flag; a load wins over a same-edge take
module word_hold_reg
  import byte_serializer_pkg::*;
#(
  parameter int W = DEFAULT_DATA_W
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      q    <= '0;
      full <= 1'b0;
    end else begin
      if (load) q <= d;
      full <= load | (full & ~take);
    end
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial converter with a one-word hold buffer for gapless streaming
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              stream_out,
  output logic              stream_valid,
  output logic              frame_done
);
  localparam int CW = $clog2(DATA_W);
  state_t            state, state_nx;
  logic [DATA_W-1:0] shift_reg, hold_q;
  logic [CW-1:0]     bit_cnt;
  logic              hold_full, take;
  assign data_ready = ~hold_full;
  word_hold_reg #(.W(DATA_W)) u_hold (
    .clk  (clk),
    .n_rst(n_rst),
    .load (data_valid & data_ready),
    .take (take),
    .d    (data_in),
    .q    (hold_q),
    .full (hold_full)
  );
  always_comb begin
    state_nx     = state;
    take         = 1'b0;
    frame_done   = 1'b0;
    stream_valid = state == SHIFT;
    stream_out   = stream_valid & (MSB_FIRST ? shift_reg[DATA_W-1] : shift_reg[0]);
    if (state == IDLE || bit_cnt == '0) begin
      frame_done = state == SHIFT;
      take       = hold_full;
      state_nx   = hold_full ? SHIFT : IDLE;
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        shift_reg <= hold_q;
        bit_cnt   <= CW'(DATA_W - 1);
      end else if (state == SHIFT) begin
        shift_reg <= MSB_FIRST ? {shift_reg[DATA_W-2:0], 1'b0} : {1'b0, shift_reg[DATA_W-1:1]};
        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed checks of bit order, latency, back-to-back framing and reset for byte_serializer
module tb_byte_serializer;
  logic       clk, n_rst;
  logic [7:0] m_din, l_din;
  logic       m_dv, l_dv, m_dr, l_dr, m_so, l_so, m_sv, l_sv, m_fd, l_fd;
  int         checks = 0, errors = 0, cyc = 0, w;
  logic       mq[$], lq[$];
  int         mc[$], mfd[$], lfd[$];

  byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .n_rst(n_rst), .data_in(m_din), .data_valid(m_dv), .data_ready(m_dr),
    .stream_out(m_so), .stream_valid(m_sv), .frame_done(m_fd)
  );
  byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .n_rst(n_rst), .data_in(l_din), .data_valid(l_dv), .data_ready(l_dr),
    .stream_out(l_so), .stream_valid(l_sv), .frame_done(l_fd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (n_rst && m_sv) begin
      mq.push_back(m_so);
      mc.push_back(cyc);
      if (m_fd) mfd.push_back(mq.size());
    end
    if (n_rst && l_sv) begin
      lq.push_back(l_so);
      if (l_fd) lfd.push_back(lq.size());
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    mq.delete(); mc.delete(); mfd.delete(); lq.delete(); lfd.delete();
  endtask

  task automatic send(input bit sel, input logic [7:0] wd, output int waited);
    waited = 0;
    if (sel) begin l_din = wd; l_dv = 1'b1; end
    else begin m_din = wd; m_dv = 1'b1; end
    while (!(sel ? l_dr : m_dr) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", waited < 100, 1);
    @(negedge clk);
    m_dv = 1'b0;
    l_dv = 1'b0;
  endtask

  function automatic logic [31:0] pack(input bit sel, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], sel ? (i < lq.size() ? lq[i] : 1'b0) : (i < mq.size() ? mq[i] : 1'b0)};
    return v;
  endfunction

  function automatic int at(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction

  function automatic int span();
    return mc.size() > 0 ? mc[mc.size()-1] - mc[0] : -1;
  endfunction

  initial begin
    n_rst = 1'b0; m_dv = 1'b0; l_dv = 1'b0; m_din = '0; l_din = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", m_dr, 1);
    check("rst_valid", m_sv, 0);
    check("rst_out", m_so, 0);
    check("rst_done", m_fd, 0);
    n_rst = 1'b1;
    @(negedge clk);
    clr();
    send(0, 8'hD0, w);
    check("lat_idle", {m_sv, m_dr}, 2'b00);
    @(negedge clk);
    check("lat_first", {m_sv, m_so}, 2'b11);
    repeat (12) @(negedge clk);
    check("d0_bits", pack(0, 8), 8'hD0);
    check("d0_len", mq.size(), 8);
    check("d0_done", at(mfd, 0), 8);
    check("d0_ndone", mfd.size(), 1);
    check("pattern_11010", pack(0, 5), 5'b11010);
    clr();
    send(0, 8'hA5, w);
    send(0, 8'h3C, w);
    repeat (20) @(negedge clk);
    check("bb_bits", pack(0, 16), 16'hA53C);
    check("bb_len", mq.size(), 16);
    check("bb_gap", span(), 15);
    check("bb_done0", at(mfd, 0), 8);
    check("bb_done1", at(mfd, 1), 16);
    clr();
    send(0, 8'h11, w);
    send(0, 8'h22, w);
    check("stall2", w > 0, 1);
    send(0, 8'h33, w);
    check("stall3", w > 0, 1);
    repeat (30) @(negedge clk);
    check("three_bits", pack(0, 24), 24'h112233);
    check("three_len", mq.size(), 24);
    check("three_gap", span(), 23);
    check("three_ndone", mfd.size(), 3);
    check("three_done2", at(mfd, 2), 24);
    clr();
    send(1, 8'h01, w);
    repeat (12) @(negedge clk);
    check("lsb_bits", pack(1, 8), 8'h80);
    check("lsb_len", lq.size(), 8);
    check("lsb_done", at(lfd, 0), 8);
    clr();
    send(0, 8'hFF, w);
    send(0, 8'hFF, w);
    repeat (2) @(negedge clk);
    check("mid_held", {m_sv, m_dr}, 2'b10);
    n_rst = 1'b0;
    #1;
    check("arst_ready", m_dr, 1);
    check("arst_valid", m_sv, 0);
    check("arst_out", m_so, 0);
    check("arst_done", m_fd, 0);
    @(negedge clk);
    n_rst = 1'b1;
    clr();
    @(negedge clk);
    send(0, 8'h80, w);
    repeat (12) @(negedge clk);
    check("post_bits", pack(0, 8), 8'h80);
    check("post_len", mq.size(), 8);
    check("post_ndone", mfd.size(), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter DATA_W, default 8, shall set the parallel word width (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, shall select the serial bit order: 1 = MSB first, 0 = LSB first.
REQ-003 clk  input  1  shall be the single clock; all state updates on the rising edge.
REQ-004 n_rst  input  1  shall be the asynchronous, active-low reset.
REQ-005 data_in  input  DATA_W  shall be the parallel word to serialize, sampled only on an accept.
REQ-006 data_valid  input  1  shall signal that data_in holds a word.
REQ-007 data_ready  output  1  shall signal that the block can accept a word this cycle.
REQ-008 stream_out  output  1  shall be the serial bit feeding the downstream pattern_detector stream_in.
REQ-009 stream_valid  output  1  shall be high in every cycle where stream_out carries a real bit.
REQ-010 frame_done  output  1  shall pulse high for the cycle that carries the last bit of a word.

Function
REQ-011 An accept shall occur on a rising edge where data_valid and data_ready are both high; data_in is then captured into a one-entry hold register.
REQ-012 data_ready shall equal NOT hold_full, combinationally from registered state only, with no dependence on data_valid.
REQ-013 The FSM shall have two states, IDLE and SHIFT.
REQ-014 IDLE: stream_valid = 0 and stream_out = 0; when hold_full = 1, move the hold word into the shift register on the next edge, clear hold_full, load bit_cnt = DATA_W-1, and go to SHIFT.
REQ-015 SHIFT: stream_valid = 1; stream_out shall be shift_reg[DATA_W-1] when MSB_FIRST = 1, otherwise shift_reg[0]; the register shall shift by one each cycle and bit_cnt shall decrement.
REQ-016 When bit_cnt = 0 in SHIFT: frame_done = 1; if hold_full = 1, load the next word and stay in SHIFT with no gap cycle; otherwise go to IDLE.
REQ-017 Latency: a word accepted at edge k shall present its first bit from edge k+1 (from IDLE with the hold register empty); back-to-back words shall produce a continuous stream_valid run of n*DATA_W cycles.
REQ-018 Simultaneous accept and hold-to-shifter transfer in the same edge shall be legal; hold_full shall then stay 1 with the new word, and no word shall be lost or duplicated.
REQ-019 data_in changes while data_ready = 0 shall have no effect.
REQ-020 bit_cnt shall be $clog2(DATA_W) bits wide and shall never wrap below 0.

Reset
REQ-021 While n_rst = 0 (asynchronously): state = IDLE, hold_full = 0, shift_reg = 0, bit_cnt = 0.
REQ-022 Reset outputs: data_ready = 1, stream_out = 0, stream_valid = 0, frame_done = 0.
REQ-023 Reset asserted mid-word shall discard both the partial word and the held word; the first accept after reset release shall start a clean frame.

Structure
REQ-024 A shared package shall hold the state enum (IDLE, SHIFT) and the default DATA_W constant.
REQ-025 The one-entry hold register with its full flag shall be a sub-module named word_hold_reg; the FSM, shift register and counter shall be in byte_serializer.

Verification
REQ-026 Reset, then accept 8'hD0 with MSB_FIRST = 1 -> stream_out 1,1,0,1,0,0,0,0 over 8 consecutive valid cycles, frame_done on the 8th.
REQ-027 Chained with pattern_detector, send 8'hD0 -> pattern_found asserts after the 5th serial bit (11010).
REQ-028 Hold data_valid high with 8'hA5 then 8'h3C -> 16 continuous valid bits 10100101 00111100, two frame_done pulses, no gap.
REQ-029 Offer 3 words with data_valid high throughout -> data_ready drops while the hold register is full, and every word is emitted exactly once in order.
REQ-030 MSB_FIRST = 0, send 8'h01 -> stream_out 1,0,0,0,0,0,0,0.
REQ-031 Assert n_rst during bit 4 of 8'hFF with a word held -> outputs reach reset values immediately, and the next accept of 8'h80 emits exactly 1,0,0,0,0,0,0,0.
